// File: rtl/mips_imem_loader.sv
`default_nettype none
// ============================================================================
// Module   : mips_imem_loader
// Brief    : Byte-stream program loader for a MIPS instruction memory, with
//            header word count, XOR checksum and CPU hold-in-reset control.
// Revision : 1.0 - initial release
// ============================================================================
module mips_imem_loader #(
    parameter int DEPTH  = 16,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic [7:0]        in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic              cpu_reset,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [ADDR_W:0]   words_loaded
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_HDR  = 3'd1,
        S_DATA = 3'd2,
        S_CSUM = 3'd3,
        S_DONE = 3'd4,
        S_ERR  = 3'd5
    } state_t;

    localparam logic [7:0] c_DEPTH = 8'(DEPTH);

    state_t            r_state;
    logic [7:0]        r_xor;
    logic [ADDR_W:0]   r_n;
    logic [1:0]        r_byte_cnt;
    logic [23:0]       r_shift;
    logic [ADDR_W:0]   w_wl_next;

    // The first three bytes of a word are held; the fourth completes it in place.
    assign w_wl_next = words_loaded + 1'b1;
    assign in_ready  = busy;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state      <= S_IDLE;
            r_xor        <= 8'h00;
            r_n          <= '0;
            r_byte_cnt   <= 2'd0;
            r_shift      <= 24'h0;
            imem_we      <= 1'b0;
            imem_addr    <= '0;
            imem_wdata   <= 32'h0;
            cpu_reset    <= 1'b1;
            busy         <= 1'b0;
            done         <= 1'b0;
            err          <= 1'b0;
            words_loaded <= '0;
        end else begin
            imem_we <= 1'b0;
            case (r_state)
                S_IDLE, S_DONE, S_ERR: begin
                    if (start) begin
                        r_state      <= S_HDR;
                        words_loaded <= '0;
                        r_xor        <= 8'h00;
                        done         <= 1'b0;
                        err          <= 1'b0;
                        cpu_reset    <= 1'b1;
                        busy         <= 1'b1;
                    end
                end
                S_HDR: begin
                    if (in_valid) begin
                        r_xor <= r_xor ^ in_data;
                        if (in_data > c_DEPTH) begin
                            r_state <= S_ERR;
                            err     <= 1'b1;
                            busy    <= 1'b0;
                        end else if (in_data == 8'h00) begin
                            r_state <= S_CSUM;
                        end else begin
                            r_state    <= S_DATA;
                            r_n        <= in_data[ADDR_W:0];
                            r_byte_cnt <= 2'd0;
                            imem_addr  <= '0;
                        end
                    end
                end
                S_DATA: begin
                    if (in_valid) begin
                        r_xor      <= r_xor ^ in_data;
                        r_shift    <= {r_shift[15:0], in_data};
                        r_byte_cnt <= r_byte_cnt + 2'd1;
                        if (r_byte_cnt == 2'd3) begin
                            imem_we      <= 1'b1;
                            imem_wdata   <= {r_shift, in_data};
                            imem_addr    <= words_loaded[ADDR_W-1:0];
                            words_loaded <= w_wl_next;
                            if (w_wl_next == r_n) begin
                                r_state <= S_CSUM;
                            end
                        end
                    end
                end
                S_CSUM: begin
                    if (in_valid) begin
                        busy <= 1'b0;
                        if (in_data == r_xor) begin
                            r_state   <= S_DONE;
                            done      <= 1'b1;
                            cpu_reset <= 1'b0;
                        end else begin
                            r_state <= S_ERR;
                            err     <= 1'b1;
                        end
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mips_imem_loader.sv
`default_nettype none
// ============================================================================
// Module   : tb_mips_imem_loader
// Brief    : Self-checking bench for mips_imem_loader: directed demo loads plus
//            randomized streams against a stream-level reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mips_imem_loader;

    localparam int DEPTH  = 16;
    localparam int ADDR_W = 4;

    logic              clk = 1'b0;
    logic              reset_n = 1'b0;
    logic              start = 1'b0;
    logic [7:0]        in_data = 8'h00;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_wdata;
    logic              cpu_reset;
    logic              busy;
    logic              done;
    logic              err;
    logic [ADDR_W:0]   words_loaded;

    int n_checks = 0;
    int n_pass   = 0;

    logic [7:0]  stream[$];
    logic [31:0] wr_addr_q[$];
    logic [31:0] wr_data_q[$];
    logic [31:0] wr_wl_q[$];

    mips_imem_loader #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .start        (start),
        .in_data      (in_data),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .imem_we      (imem_we),
        .imem_addr    (imem_addr),
        .imem_wdata   (imem_wdata),
        .cpu_reset    (cpu_reset),
        .busy         (busy),
        .done         (done),
        .err          (err),
        .words_loaded (words_loaded)
    );

    always #5 clk = ~clk;

    // Every cycle with a write strobe is logged, so a stuck strobe shows up as extra writes.
    always @(negedge clk) begin
        if (imem_we) begin
            wr_addr_q.push_back(32'(imem_addr));
            wr_data_q.push_back(imem_wdata);
            wr_wl_q.push_back(32'(words_loaded));
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    task automatic clear_log();
        wr_addr_q.delete();
        wr_data_q.delete();
        wr_wl_q.delete();
    endtask

    task automatic do_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // mode 0: valid always, 1: valid toggles, 2: random valid
    task automatic drive(input int mode, input int max_bytes, input int mid_start_at);
        int  idx = 0;
        int  cyc = 0;
        bit  v;
        bit  xfer;
        bit  started = 0;
        while (idx < stream.size() && idx < max_bytes && cyc < 2000) begin
            if (!busy) break;
            case (mode)
                0:       v = 1'b1;
                1:       v = ((cyc % 2) == 0);
                default: v = 1'($urandom_range(0, 1));
            endcase
            in_valid = v;
            in_data  = stream[idx];
            if (!started && mid_start_at >= 0 && idx == mid_start_at) begin
                start   = 1'b1;
                started = 1;
            end
            xfer = v && in_ready;
            @(posedge clk);
            if (xfer) idx++;
            cyc++;
            @(negedge clk);
            start = 1'b0;
        end
        in_valid = 1'b0;
        if (cyc >= 2000) check("timeout", 32'(cyc), 32'd0);
    endtask

    // Reference: the stream's meaning derived straight from its format rules.
    task automatic check_result(input string name);
        int          n;
        logic [7:0]  x;
        logic [31:0] w;
        bit          exp_done;
        int          nw;
        n = int'(stream[0]);
        if (n > DEPTH) begin
            nw = 0;
            exp_done = 0;
        end else begin
            nw = n;
            x = 8'h00;
            for (int i = 0; i <= 4 * n; i++) x ^= stream[i];
            exp_done = (stream[4 * n + 1] == x);
        end
        check({name, ".nwrites"}, 32'(wr_addr_q.size()), 32'(nw));
        for (int i = 0; i < nw && i < wr_addr_q.size(); i++) begin
            w = {stream[1 + 4 * i], stream[2 + 4 * i], stream[3 + 4 * i], stream[4 + 4 * i]};
            check($sformatf("%s.addr%0d", name, i), wr_addr_q[i], 32'(i));
            check($sformatf("%s.data%0d", name, i), wr_data_q[i], w);
            check($sformatf("%s.wl%0d", name, i), wr_wl_q[i], 32'(i + 1));
        end
        check({name, ".done"}, 32'(done), 32'(exp_done));
        check({name, ".err"}, 32'(err), 32'(!exp_done));
        check({name, ".cpu_reset"}, 32'(cpu_reset), 32'(!exp_done));
        check({name, ".words_loaded"}, 32'(words_loaded), 32'(nw));
        check({name, ".busy"}, 32'(busy), 32'd0);
        check({name, ".in_ready"}, 32'(in_ready), 32'd0);
    endtask

    task automatic load_demo(input logic [7:0] csum);
        logic [7:0] demo[26] = '{8'h05,
            8'h20, 8'h01, 8'h00, 8'h05, 8'h20, 8'h02, 8'h00, 8'h0A,
            8'h00, 8'h22, 8'h18, 8'h20, 8'h00, 8'h60, 8'h20, 8'h20,
            8'hAC, 8'h04, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        stream.delete();
        for (int i = 0; i < 21; i++) stream.push_back(demo[i]);
        stream.push_back(csum);
    endtask

    task automatic check_reset_values(input string name);
        check({name, ".in_ready"}, 32'(in_ready), 32'd0);
        check({name, ".imem_we"}, 32'(imem_we), 32'd0);
        check({name, ".busy"}, 32'(busy), 32'd0);
        check({name, ".done"}, 32'(done), 32'd0);
        check({name, ".err"}, 32'(err), 32'd0);
        check({name, ".cpu_reset"}, 32'(cpu_reset), 32'd1);
        check({name, ".imem_addr"}, 32'(imem_addr), 32'd0);
        check({name, ".imem_wdata"}, imem_wdata, 32'd0);
        check({name, ".words_loaded"}, 32'(words_loaded), 32'd0);
    endtask

    initial begin
        int         n;
        logic [7:0] x;
        repeat (3) @(negedge clk);
        check_reset_values("por");
        reset_n = 1'b1;
        @(negedge clk);
        check_reset_values("idle");

        clear_log(); load_demo(8'hDB); do_start(); drive(0, 1000, -1);
        check_result("demo");
        check("demo.csum_model", 32'(stream[21]), 32'h0000_00DB);

        clear_log(); load_demo(8'hDA); do_start(); drive(0, 1000, -1);
        check_result("badcsum");

        clear_log();
        stream.delete(); stream.push_back(8'h11); stream.push_back(8'h00);
        do_start(); drive(0, 1000, -1);
        check_result("hdr11");

        clear_log();
        stream.delete(); stream.push_back(8'h00); stream.push_back(8'h00);
        do_start(); drive(0, 1000, -1);
        check_result("empty");

        clear_log(); load_demo(8'hDB); do_start(); drive(1, 1000, 10);
        check_result("toggle");

        // Abort partway through the second word with an asynchronous reset.
        clear_log(); load_demo(8'hDB); do_start(); drive(0, 8, -1);
        check("abort.pre_writes", 32'(wr_addr_q.size()), 32'd1);
        #2 reset_n = 1'b0;
        #1 check_reset_values("abort");
        @(negedge clk);
        reset_n = 1'b1;
        clear_log();
        in_valid = 1'b1;
        repeat (10) begin
            in_data = 8'($urandom);
            @(negedge clk);
        end
        in_valid = 1'b0;
        check("abort.post_writes", 32'(wr_addr_q.size()), 32'd0);
        check("abort.post_ready", 32'(in_ready), 32'd0);
        clear_log(); load_demo(8'hDB); do_start(); drive(0, 1000, -1);
        check_result("reload");

        for (int t = 0; t < 12; t++) begin
            clear_log();
            stream.delete();
            n = $urandom_range(0, DEPTH + 3);
            stream.push_back(8'(n));
            x = 8'(n);
            if (n <= DEPTH) begin
                for (int i = 0; i < 4 * n; i++) begin
                    stream.push_back(8'($urandom));
                    x ^= stream[stream.size() - 1];
                end
                if ($urandom_range(0, 3) == 0) x ^= 8'($urandom_range(1, 255));
                stream.push_back(x);
            end else begin
                stream.push_back(8'($urandom));
            end
            do_start();
            drive(2, 1000, (t % 3 == 0) ? 3 : -1);
            check_result($sformatf("rand%0d", t));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mips_imem_loader.md
MIPS_IMEM_LOADER -- requirements
Module: mips_imem_loader

Interface
REQ-001: Parameter DEPTH, default 16: instruction-memory depth in 32-bit words.
REQ-002: Parameter ADDR_W, default 4: instruction-memory address width; DEPTH SHALL equal 2**ADDR_W.
REQ-003: clk  input  1  single clock; all state changes on its rising edge.
REQ-004: reset_n  input  1  reset, asynchronous assertion, active-low.
REQ-005: start  input  1  one-cycle request to begin a program load.
REQ-006: in_data  input  8  byte stream payload.
REQ-007: in_valid  input  1  in_data is valid this cycle.
REQ-008: in_ready  output  1  loader accepts a byte this cycle; transfer occurs when in_valid and in_ready are both 1.
REQ-009: imem_we  output  1  instruction-memory write strobe.
REQ-010: imem_addr  output  ADDR_W  word write address.
REQ-011: imem_wdata  output  32  instruction word to write.
REQ-012: cpu_reset  output  1  active-high hold-in-reset for the downstream CPU.
REQ-013: busy  output  1  a load is in progress.
REQ-014: done  output  1  last load completed with a good checksum.
REQ-015: err  output  1  last load was aborted.
REQ-016: words_loaded  output  ADDR_W+1  number of words written in the current or last load.

Function
REQ-017: Stream format: header byte N (word count), then 4*N data bytes (MSB first within each word), then one checksum byte.
REQ-018: The checksum byte SHALL equal the XOR of the header and all data bytes.
REQ-019: States: IDLE, HDR, DATA, CSUM, DONE, ERR.
- busy = 1 in HDR, DATA and CSUM.
- in_ready = busy; in_ready = 0 in IDLE, DONE and ERR.
REQ-020: IDLE, DONE or ERR with start=1 -> HDR, with:
- words_loaded cleared to 0;
- running XOR cleared;
- done and err cleared;
- cpu_reset set to 1.
REQ-021: start is ignored in HDR, DATA and CSUM.
REQ-022: HDR, on header accept:
- N > DEPTH -> ERR;
- N = 0 -> CSUM;
- otherwise -> DATA, with the byte counter and imem_addr cleared to 0.
REQ-023: DATA: each accepted byte shifts into a 32-bit assembly register with a 2-bit byte counter that wraps 3 -> 0.
REQ-024: On acceptance of the 4th byte of a word:
- the next cycle imem_we = 1 for exactly one cycle, with the assembled word on imem_wdata and the word index on imem_addr;
- words_loaded increments in that same cycle.
REQ-025: After the 4th byte of word N-1 is accepted -> CSUM; in_ready stays 1 and no backpressure is applied.
REQ-026: CSUM, on checksum accept:
- match -> DONE;
- mismatch -> ERR.
REQ-027: DONE: done = 1 and cpu_reset = 0, held until the next start.
REQ-028: ERR: err = 1 and cpu_reset = 1; writes already performed are not undone.
REQ-029: Cycles with in_valid = 0 SHALL stall the FSM with no state, counter or XOR change.
REQ-030: imem_we SHALL be 0 in every state except the single cycle defined in REQ-024.

Reset
REQ-031: reset_n = 0 SHALL immediately force:
- state IDLE;
- in_ready = 0, imem_we = 0, busy = 0, done = 0, err = 0;
- cpu_reset = 1;
- imem_addr = 0, imem_wdata = 0, words_loaded = 0;
- all counters and the XOR cleared.
REQ-032: A reset during a load SHALL abandon the load; no imem_we follows reset release without a new start.

Verification
REQ-033: Demo load, with start then in_valid held 1:
- stream 05, 20 01 00 05, 20 02 00 0A, 00 22 18 20, 00 60 20 20, AC 04 00 00, DB;
- required: five imem_we pulses at addr 0..4 with data 20010005, 2002000A, 00221820, 00602020, AC040000;
- then done = 1, cpu_reset = 0, words_loaded = 5.
REQ-034: Same stream with checksum DA -> five writes, then err = 1, done = 0, cpu_reset = 1.
REQ-035: Header 11 (hex) -> ERR on the cycle after the header, zero writes, in_ready = 0.
REQ-036: Header 00 followed by checksum 00 -> done = 1, zero writes, words_loaded = 0.
REQ-037: Demo stream with in_valid toggling 1/0 every cycle, plus start pulsed mid-DATA:
- identical writes and final status to REQ-033;
- start has no effect.
REQ-038: reset_n low for one cycle after the 7th data byte of the demo stream:
- all outputs at reset values immediately;
- no further imem_we;
- a fresh start plus the full stream then completes per REQ-033.
